// File: rtl/multiply_by_d_csd_unit_pkg.sv
// rtl/multiply_by_d_csd_unit_pkg.sv - CSD digit encodings and signed-digit multiply helper
package multiply_by_d_csd_unit_pkg;

  typedef logic [1:0] csd_digit_t;

  localparam csd_digit_t CSD_ZERO = 2'b00;
  localparam csd_digit_t CSD_POS  = 2'b10;
  localparam csd_digit_t CSD_NEG  = 2'b01;

  // Negation swaps p and n, so a tolerated 2'b11 digit maps onto itself.
  function automatic csd_digit_t csd_digit_mul(input csd_digit_t d, input csd_digit_t digit);
    case (d)
      CSD_POS: return digit;
      CSD_NEG: return {digit[0], digit[1]};
      default: return CSD_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/multiply_by_d_csd_unit_if.sv
// rtl/multiply_by_d_csd_unit_if.sv - operand, digit and product bundle for the BKM digit multiplier
interface multiply_by_d_csd_unit_if #(
  parameter int W = 4
);
  logic [1:0]     d_x;
  logic [1:0]     d_y;
  logic [2*W-1:0] x_in;
  logic [2*W-1:0] y_in;
  logic [2*W-1:0] x_out;
  logic [2*W-1:0] y_out;

  modport master (
    output d_x, d_y, x_in, y_in,
    input  x_out, y_out
  );

  modport slave (
    input  d_x, d_y, x_in, y_in,
    output x_out, y_out
  );
endinterface

// File: rtl/multiply_by_d_csd_unit_scale.sv
// rtl/multiply_by_d_csd_unit_scale.sv - combinational per-digit scaling of a CSD word by one signed digit
module multiply_by_d_csd_unit_scale
  import multiply_by_d_csd_unit_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [1:0]     d,
  input  logic [2*W-1:0] word_in,
  output logic [2*W-1:0] word_out
);

  for (genvar i = 0; i < W; i++) begin : g_digit
    assign word_out[2*i+1:2*i] = csd_digit_mul(d, word_in[2*i+1:2*i]);
  end

endmodule

// File: rtl/multiply_by_d_csd_unit.sv
// rtl/multiply_by_d_csd_unit.sv - registered X/Y CSD operand scaling by signed digits for the BKM datapath
module multiply_by_d_csd_unit
  import multiply_by_d_csd_unit_pkg::*;
#(
  parameter int W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  multiply_by_d_csd_unit_if.slave bus
);

  logic [2*W-1:0] x_scaled;
  logic [2*W-1:0] y_scaled;
  logic [2*W-1:0] x_q;
  logic [2*W-1:0] y_q;

  multiply_by_d_csd_unit_scale #(.W(W)) u_scale_x (
    .d        (bus.d_x),
    .word_in  (bus.x_in),
    .word_out (x_scaled)
  );

  multiply_by_d_csd_unit_scale #(.W(W)) u_scale_y (
    .d        (bus.d_y),
    .word_in  (bus.y_in),
    .word_out (y_scaled)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= {W{CSD_ZERO}};
      y_q <= {W{CSD_ZERO}};
    end else begin
      x_q <= x_scaled;
      y_q <= y_scaled;
    end
  end

  assign bus.x_out = x_q;
  assign bus.y_out = y_q;

endmodule

// File: tb/tb_multiply_by_d_csd_unit.sv
// tb/tb_multiply_by_d_csd_unit.sv - self-checking bench for the BKM CSD digit multiplier
module tb_multiply_by_d_csd_unit;

  localparam int W = 4;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  multiply_by_d_csd_unit_if #(.W(W)) bus ();

  multiply_by_d_csd_unit #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] dx;
    logic [1:0] dy;
    int         xv;
    int         yv;
    int         ex;
    int         ey;
  } vec_t;

  vec_t tbl[7];

  function automatic int wrap_w(input int v);
    logic signed [W-1:0] t;
    t = v[W-1:0];
    return int'(t);
  endfunction

  function automatic int dval(input logic [1:0] d);
    if (d == 2'b10) return 1;
    if (d == 2'b01) return -1;
    return 0;
  endfunction

  // Non-adjacent form of a W-bit signed value.
  function automatic logic [2*W-1:0] bin2csd(input int v);
    logic [2*W-1:0] w;
    int r;
    int z;
    w = '0;
    r = v;
    for (int i = 0; i < W; i++) begin
      if ((r & 1) != 0) begin
        z = ((r & 3) == 1) ? 1 : -1;
        w[2*i+1] = (z == 1);
        w[2*i]   = (z == -1);
        r = (r - z) / 2;
      end else begin
        r = r / 2;
      end
    end
    return w;
  endfunction

  function automatic int csd2bin(input logic [2*W-1:0] w);
    int s;
    s = 0;
    for (int i = 0; i < W; i++)
      s += (int'(w[2*i+1]) - int'(w[2*i])) * (1 << i);
    return wrap_w(s);
  endfunction

  function automatic int is_naf(input logic [2*W-1:0] w);
    for (int i = 0; i < W-1; i++)
      if ((w[2*i+1] != w[2*i]) && (w[2*i+3] != w[2*i+2])) return 0;
    return 1;
  endfunction

  // Expected word from the digit rule: keep, swap p/n, or clear each digit.
  function automatic logic [2*W-1:0] ref_word(input logic [1:0] d, input logic [2*W-1:0] w);
    logic [2*W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      if (dval(d) == 1)       r[2*i +: 2] = w[2*i +: 2];
      else if (dval(d) == -1) r[2*i +: 2] = {w[2*i], w[2*i+1]};
    end
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input logic [1:0] dx, input logic [1:0] dy,
                       input logic [2*W-1:0] xw, input logic [2*W-1:0] yw);
    @(negedge clk);
    bus.d_x  = dx;
    bus.d_y  = dy;
    bus.x_in = xw;
    bus.y_in = yw;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2*W-1:0] xw;
    logic [2*W-1:0] yw;
    logic [1:0]     dx;
    logic [1:0]     dy;
    n_vec = 0;
    n_err = 0;

    tbl[0] = '{2'b10, 2'b10,  5, -3,  5, -3};
    tbl[1] = '{2'b01, 2'b01,  7, -6, -7,  6};
    tbl[2] = '{2'b01, 2'b01, -8, -8, -8, -8};
    tbl[3] = '{2'b00, 2'b01,  3,  2,  0, -2};
    tbl[4] = '{2'b11, 2'b11,  3,  2,  0,  0};
    tbl[5] = '{2'b10, 2'b01,  4, -5,  4,  5};
    tbl[6] = '{2'b01, 2'b10,  4, -5, -4, -5};

    rst = 1'b1;
    bus.d_x  = 2'b10;
    bus.d_y  = 2'b10;
    bus.x_in = bin2csd(5);
    bus.y_in = bin2csd(-3);
    #3;
    check("reset_x", int'(bus.x_out), 0);
    check("reset_y", int'(bus.y_out), 0);
    @(posedge clk);
    #1;
    check("reset_hold_x", int'(bus.x_out), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      apply(tbl[i].dx, tbl[i].dy, bin2csd(tbl[i].xv), bin2csd(tbl[i].yv));
      check($sformatf("tbl%0d_x", i), csd2bin(bus.x_out), tbl[i].ex);
      check($sformatf("tbl%0d_y", i), csd2bin(bus.y_out), tbl[i].ey);
    end

    // Tolerated 2'b11 digits survive pass and negate, clear under zero.
    apply(2'b01, 2'b10, 8'hFF, 8'hFF);
    check("d11_neg_x", int'(bus.x_out), 8'hFF);
    check("d11_pos_y", int'(bus.y_out), 8'hFF);
    apply(2'b00, 2'b11, 8'hFF, 8'hFF);
    check("d11_zero_x", int'(bus.x_out), 0);
    check("d11_zero_y", int'(bus.y_out), 0);

    // Asynchronous reset between edges, then recovery.
    apply(2'b10, 2'b01, bin2csd(5), bin2csd(3));
    check("pre_rst_x", csd2bin(bus.x_out), 5);
    check("pre_rst_y", csd2bin(bus.y_out), -3);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_x", int'(bus.x_out), 0);
    check("async_rst_y", int'(bus.y_out), 0);
    @(posedge clk);
    #1;
    check("rst_held_x", int'(bus.x_out), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_x", csd2bin(bus.x_out), 5);
    check("post_rst_y", csd2bin(bus.y_out), -3);

    // Sweep every x/y value with every digit code on each axis.
    for (int xv = -8; xv < 8; xv++) begin
      for (int yv = -8; yv < 8; yv++) begin
        for (int k = 0; k < 4; k++) begin
          dx = 2'(k);
          dy = 2'(k) ^ 2'(xv);
          xw = bin2csd(xv);
          yw = bin2csd(yv);
          apply(dx, dy, xw, yw);
          check("sweep_x", csd2bin(bus.x_out), wrap_w(dval(dx) * xv));
          check("sweep_y", csd2bin(bus.y_out), wrap_w(dval(dy) * yv));
          check("sweep_naf_x", is_naf(bus.x_out), 1);
          check("sweep_naf_y", is_naf(bus.y_out), 1);
        end
      end
    end

    // Raw random words, including 2'b11 digits.
    for (int n = 0; n < 300; n++) begin
      dx = 2'($urandom_range(0, 3));
      dy = 2'($urandom_range(0, 3));
      xw = 8'($urandom);
      yw = 8'($urandom);
      apply(dx, dy, xw, yw);
      check("rand_word_x", int'(bus.x_out), int'(ref_word(dx, xw)));
      check("rand_word_y", int'(bus.y_out), int'(ref_word(dy, yw)));
      check("rand_val_x", csd2bin(bus.x_out), wrap_w(dval(dx) * csd2bin(xw)));
      check("rand_val_y", csd2bin(bus.y_out), wrap_w(dval(dy) * csd2bin(yw)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
